// File: rtl/dffram_arbiter_2p.sv
// Two-port front end for one dffram_8x32 single-port RAM: per-cycle arbitration,
// RAM pin drive, one-cycle response pulses and a post-reset zero-fill sequencer.
module dffram_arbiter_2p #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [3:0]  p0_we,
    input  logic [2:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rdata,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [3:0]  p1_we,
    input  logic [2:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [2:0]  ram_a,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do,

    output logic        busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t     state_q;
    logic [2:0] clr_cnt_q;
    logic       last_q;
    logic       busy_q;
    logic       p0_rsp_q;
    logic       p1_rsp_q;
    logic       gnt0_s;
    logic       gnt1_s;

    // Arbitration; grants are suppressed while reset is held so nothing leaks onto the RAM.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!RST && (state_q == ST_RUN)) begin
            if (p0_valid && p1_valid) begin
                if (FIXED_PRIO || last_q) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else begin
                gnt0_s = p0_valid;
                gnt1_s = p1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign p0_ready = gnt0_s;
    assign p1_ready = gnt1_s;

    // RAM pin multiplexer: clear sequencer, granted port, or idle zeros.
    always_comb begin
        ram_en = 1'b0;
        ram_we = 4'h0;
        ram_a  = 3'd0;
        ram_di = 32'h0000_0000;
        if (RST) begin
            ram_en = 1'b0;
            ram_we = 4'h0;
        end else if (state_q == ST_CLEAR) begin
            ram_en = 1'b1;
            ram_we = 4'hF;
            ram_a  = clr_cnt_q;
            ram_di = 32'h0000_0000;
        end else if (gnt0_s) begin
            ram_en = 1'b1;
            ram_we = p0_we;
            ram_a  = p0_addr;
            ram_di = p0_wdata;
        end else if (gnt1_s) begin
            ram_en = 1'b1;
            ram_we = p1_we;
            ram_a  = p1_addr;
            ram_di = p1_wdata;
        end else begin
            ram_en = 1'b0;
            ram_we = 4'h0;
        end
    end

    // Control FSM with registered busy flag, round-robin pointer and response pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= 3'd0;
            busy_q    <= CLEAR_ON_RESET;
            last_q    <= 1'b1;
            p0_rsp_q  <= 1'b0;
            p1_rsp_q  <= 1'b0;
        end else begin
            p0_rsp_q <= gnt0_s;
            p1_rsp_q <= gnt1_s;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 3'd1;
                    if (clr_cnt_q == 3'd7) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (gnt0_s) begin
                        last_q <= 1'b0;
                    end else if (gnt1_s) begin
                        last_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RESET_STATE;
                    busy_q  <= CLEAR_ON_RESET;
                end
            endcase
        end
    end

    assign p0_rsp_valid = p0_rsp_q;
    assign p1_rsp_valid = p1_rsp_q;
    // The RAM reads before it writes, so ram_do in T+1 is the pre-write word for either port.
    assign p0_rdata     = ram_do;
    assign p1_rdata     = ram_do;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dffram_arbiter_2p.sv
// Directed bench: a round-robin instance (a_) and a fixed-priority instance (f_) share
// stimulus, each backed by its own behavioural read-before-write 8x32 RAM.
module tb_dffram_arbiter_2p;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        p0_valid, p1_valid;
    logic [3:0]  p0_we, p1_we;
    logic [2:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    logic        a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid, a_ram_en, a_busy;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_ram_di, a_ram_do;
    logic [3:0]  a_ram_we;
    logic [2:0]  a_ram_a;
    logic        f_p0_ready, f_p1_ready, f_p0_rsp_valid, f_p1_rsp_valid, f_ram_en, f_busy;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_ram_di, f_ram_do;
    logic [3:0]  f_ram_we;
    logic [2:0]  f_ram_a;

    logic [31:0] a_mem [8];
    logic [31:0] f_mem [8];

    int tests_run = 0;
    int fails     = 0;

    always #5 CLK = ~CLK;

    dffram_arbiter_2p #(.CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b0)) u_rr (
        .CLK(CLK), .RST(RST),
        .p0_valid(p0_valid), .p0_ready(a_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rsp_valid(a_p0_rsp_valid), .p0_rdata(a_p0_rdata),
        .p1_valid(p1_valid), .p1_ready(a_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rsp_valid(a_p1_rsp_valid), .p1_rdata(a_p1_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_a(a_ram_a), .ram_di(a_ram_di),
        .ram_do(a_ram_do), .busy(a_busy)
    );

    dffram_arbiter_2p #(.CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b1)) u_fp (
        .CLK(CLK), .RST(RST),
        .p0_valid(p0_valid), .p0_ready(f_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rsp_valid(f_p0_rsp_valid), .p0_rdata(f_p0_rdata),
        .p1_valid(p1_valid), .p1_ready(f_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rsp_valid(f_p1_rsp_valid), .p1_rdata(f_p1_rdata),
        .ram_en(f_ram_en), .ram_we(f_ram_we), .ram_a(f_ram_a), .ram_di(f_ram_di),
        .ram_do(f_ram_do), .busy(f_busy)
    );

    // Behavioural dffram_8x32 models: registered read of the old word, byte-masked write.
    always @(posedge CLK) begin
        if (a_ram_en) begin
            a_ram_do <= a_mem[a_ram_a];
            for (int b = 0; b < 4; b++)
                if (a_ram_we[b]) a_mem[a_ram_a][8*b +: 8] <= a_ram_di[8*b +: 8];
        end
        if (f_ram_en) begin
            f_ram_do <= f_mem[f_ram_a];
            for (int b = 0; b < 4; b++)
                if (f_ram_we[b]) f_mem[f_ram_a][8*b +: 8] <= f_ram_di[8*b +: 8];
        end
    end

    task automatic drive(input logic v0, input logic [3:0] we0, input logic [2:0] a0,
                         input logic [31:0] d0, input logic v1, input logic [3:0] we1,
                         input logic [2:0] a1, input logic [31:0] d1);
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 4'h0, 3'd2, 32'h0, 1'b1, 4'h0, 3'd4, 32'h0);
        repeat (2) @(posedge CLK);
        #4;
        tests_run++;
        if ({a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid, a_ram_en, a_ram_we, a_busy} !== 10'h001) begin
            fails++;
            $display("FAIL reset_hold_rr: got %h expected %h",
                     {a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid, a_ram_en, a_ram_we, a_busy}, 10'h001);
        end
        tests_run++;
        if ({f_p0_ready, f_p1_ready, f_p0_rsp_valid, f_p1_rsp_valid, f_ram_en, f_ram_we, f_busy} !== 10'h001) begin
            fails++;
            $display("FAIL reset_hold_fp: got %h expected %h",
                     {f_p0_ready, f_p1_ready, f_p0_rsp_valid, f_p1_rsp_valid, f_ram_en, f_ram_we, f_busy}, 10'h001);
        end
        step();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #3;
            tests_run++;
            if ({a_busy, a_ram_en, a_ram_we, a_ram_a, a_ram_di, a_p0_ready, a_p1_ready} !==
                {1'b1, 1'b1, 4'hF, 3'(i), 32'h0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL clear_step_rr[%0d]: got %h expected %h", i,
                         {a_busy, a_ram_en, a_ram_we, a_ram_a, a_ram_di, a_p0_ready, a_p1_ready},
                         {1'b1, 1'b1, 4'hF, 3'(i), 32'h0, 1'b0, 1'b0});
            end
            tests_run++;
            if ({f_busy, f_ram_en, f_ram_a, f_p0_ready, f_p1_ready} !== {1'b1, 1'b1, 3'(i), 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL clear_step_fp[%0d]: got %h expected %h", i,
                         {f_busy, f_ram_en, f_ram_a, f_p0_ready, f_p1_ready}, {1'b1, 1'b1, 3'(i), 1'b0, 1'b0});
            end
            step();
        end
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_busy, f_busy, a_ram_en, f_ram_en} !== 4'b0000) begin
            fails++;
            $display("FAIL clear_done: got %b expected %b", {a_busy, f_busy, a_ram_en, f_ram_en}, 4'b0000);
        end
        step();
    endtask

    task automatic test_p0_write_read();
        drive(1'b1, 4'hF, 3'd5, 32'hDEADBEEF, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_ready, a_p1_ready, a_ram_en, a_ram_we, a_ram_a, a_ram_di} !==
            {1'b1, 1'b0, 1'b1, 4'hF, 3'd5, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL p0_write_drive: got %h expected %h",
                     {a_p0_ready, a_p1_ready, a_ram_en, a_ram_we, a_ram_a, a_ram_di},
                     {1'b1, 1'b0, 1'b1, 4'hF, 3'd5, 32'hDEADBEEF});
        end
        step();
        drive(1'b1, 4'h0, 3'd5, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata, a_p0_ready} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
            fails++;
            $display("FAIL p0_write_rsp_old: got %h expected %h",
                     {a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata, a_p0_ready}, {1'b1, 1'b0, 32'h0, 1'b1});
        end
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p0_rdata, a_ram_en} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            fails++;
            $display("FAIL p0_read_rsp: got %h expected %h",
                     {a_p0_rsp_valid, a_p0_rdata, a_ram_en}, {1'b1, 32'hDEADBEEF, 1'b0});
        end
        step();
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p1_rsp_valid} !== 2'b00) begin
            fails++;
            $display("FAIL p0_rsp_one_cycle: got %b expected %b", {a_p0_rsp_valid, a_p1_rsp_valid}, 2'b00);
        end
        step();
    endtask

    task automatic test_p1_byte_write();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'b0010, 3'd5, 32'h0000AB00);
        #3;
        tests_run++;
        if ({a_p0_ready, a_p1_ready, a_ram_we, a_ram_a} !== {1'b0, 1'b1, 4'b0010, 3'd5}) begin
            fails++;
            $display("FAIL p1_byte_write_drive: got %h expected %h",
                     {a_p0_ready, a_p1_ready, a_ram_we, a_ram_a}, {1'b0, 1'b1, 4'b0010, 3'd5});
        end
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'd5, 32'h0);
        #3;
        tests_run++;
        if ({a_p1_rsp_valid, a_p0_rsp_valid, a_p1_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL p1_write_rsp_old: got %h expected %h",
                     {a_p1_rsp_valid, a_p0_rsp_valid, a_p1_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        end
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p1_rsp_valid, a_p1_rdata} !== {1'b1, 32'hDEADABEF}) begin
            fails++;
            $display("FAIL p1_byte_merge_rr: got %h expected %h", {a_p1_rsp_valid, a_p1_rdata}, {1'b1, 32'hDEADABEF});
        end
        tests_run++;
        if ({f_p1_rsp_valid, f_p1_rdata} !== {1'b1, 32'hDEADABEF}) begin
            fails++;
            $display("FAIL p1_byte_merge_fp: got %h expected %h", {f_p1_rsp_valid, f_p1_rdata}, {1'b1, 32'hDEADABEF});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic exp0;
        drive(1'b1, 4'h0, 3'd5, 32'h0, 1'b1, 4'h0, 3'd3, 32'h0);
        for (int i = 0; i < 6; i++) begin
            exp0 = (i % 2 == 0);
            #3;
            tests_run++;
            if ({a_p0_ready, a_p1_ready} !== {exp0, !exp0}) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, {a_p0_ready, a_p1_ready}, {exp0, !exp0});
            end
            tests_run++;
            if ({f_p0_ready, f_p1_ready} !== 2'b10) begin
                fails++;
                $display("FAIL fp_grant[%0d]: got %b expected %b", i, {f_p0_ready, f_p1_ready}, 2'b10);
            end
            if (i > 0) begin
                tests_run++;
                if ({a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata} !==
                    {!exp0, exp0, (exp0 ? 32'h0 : 32'hDEADABEF)}) begin
                    fails++;
                    $display("FAIL rr_rsp[%0d]: got %h expected %h", i,
                             {a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata},
                             {!exp0, exp0, (exp0 ? 32'h0 : 32'hDEADABEF)});
                end
                tests_run++;
                if ({f_p0_rsp_valid, f_p1_rsp_valid, f_p0_rdata} !== {1'b1, 1'b0, 32'hDEADABEF}) begin
                    fails++;
                    $display("FAIL fp_rsp[%0d]: got %h expected %h", i,
                             {f_p0_rsp_valid, f_p1_rsp_valid, f_p0_rdata}, {1'b1, 1'b0, 32'hDEADABEF});
                end
            end
            step();
        end
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p1_rsp_valid, f_p0_rsp_valid, f_p1_rsp_valid} !== 4'b0110) begin
            fails++;
            $display("FAIL b2b_last_rsp: got %b expected %b",
                     {a_p0_rsp_valid, a_p1_rsp_valid, f_p0_rsp_valid, f_p1_rsp_valid}, 4'b0110);
        end
        step();
    endtask

    task automatic test_single_then_tie();
        logic [1:0] exp_rdy;
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'd3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) drive(1'b1, 4'h0, 3'd5, 32'h0, 1'b1, 4'h0, 3'd3, 32'h0);
            exp_rdy = (i < 3) ? 2'b01 : 2'b10;
            #3;
            tests_run++;
            if ({a_p0_ready, a_p1_ready, f_p0_ready, f_p1_ready} !== {exp_rdy, exp_rdy}) begin
                fails++;
                $display("FAIL single_then_tie[%0d]: got %b expected %b", i,
                         {a_p0_ready, a_p1_ready, f_p0_ready, f_p1_ready}, {exp_rdy, exp_rdy});
            end
            step();
        end
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata} !== {1'b1, 1'b0, 32'hDEADABEF}) begin
            fails++;
            $display("FAIL tie_rsp: got %h expected %h",
                     {a_p0_rsp_valid, a_p1_rsp_valid, a_p0_rdata}, {1'b1, 1'b0, 32'hDEADABEF});
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'h0, 3'd5, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if (a_p0_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_pre_grant: got %b expected %b", a_p0_ready, 1'b1);
        end
        RST = 1'b1;
        #1;
        tests_run++;
        if ({a_p0_ready, a_ram_en, a_busy} !== 3'b001) begin
            fails++;
            $display("FAIL mid_reset_async: got %b expected %b", {a_p0_ready, a_ram_en, a_busy}, 3'b001);
        end
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_busy, a_ram_en} !== 3'b010) begin
            fails++;
            $display("FAIL mid_reset_drop: got %b expected %b", {a_p0_rsp_valid, a_busy, a_ram_en}, 3'b010);
        end
        step();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #3;
            tests_run++;
            if ({a_busy, a_ram_en, a_ram_we, a_ram_a, a_p0_rsp_valid} !== {1'b1, 1'b1, 4'hF, 3'(i), 1'b0}) begin
                fails++;
                $display("FAIL mid_reset_clear[%0d]: got %h expected %h", i,
                         {a_busy, a_ram_en, a_ram_we, a_ram_a, a_p0_rsp_valid}, {1'b1, 1'b1, 4'hF, 3'(i), 1'b0});
            end
            step();
        end
        drive(1'b1, 4'h0, 3'd5, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_busy, a_p0_ready} !== 2'b01) begin
            fails++;
            $display("FAIL post_reset_grant: got %b expected %b", {a_busy, a_p0_ready}, 2'b01);
        end
        step();
        drive(1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0);
        #3;
        tests_run++;
        if ({a_p0_rsp_valid, a_p0_rdata} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL post_reset_read: got %h expected %h", {a_p0_rsp_valid, a_p0_rdata}, {1'b1, 32'h0});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_p0_write_read();
        test_p1_byte_write();
        test_back_to_back();
        test_single_then_tie();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
